// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full-adder step per clock, LSB first.
// Result (z, c, v) is registered and only updated on completion, with a
// one-cycle done pulse marking the new value.
module serial_adder #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         cIn,
    output logic [N-1:0] z,
    output logic         c,
    output logic         v,
    output logic         busy,
    output logic         done
);

    localparam int unsigned CntW = $clog2(N + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CntW-1:0] LastBit = CntW'(N - 1);

    logic [1:0]      state;
    logic [1:0]      stateNext;
    logic [N-1:0]    xReg;
    logic [N-1:0]    yReg;
    logic [N-1:0]    sumReg;
    logic            carryReg;
    logic [CntW-1:0] count;

    logic            sumBit;
    logic            carryOut;
    logic            lastStep;

    // Full-adder step on the current operand LSBs and carry
    always_comb begin
        sumBit   = xReg[0] ^ yReg[0] ^ carryReg;
        carryOut = (xReg[0] & yReg[0]) | (carryReg & (xReg[0] ^ yReg[0]));
        lastStep = (count == LastBit);
    end

    // Next-state decode: IDLE -> RUN on start, RUN -> DONE after bit N-1, DONE -> IDLE
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (start) stateNext = RUN;
            RUN:     if (lastStep) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Operand/carry/sum shift registers and the bit counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xReg     <= '0;
            yReg     <= '0;
            sumReg   <= '0;
            carryReg <= 1'b0;
            count    <= '0;
        end else if (state == IDLE && start) begin
            xReg     <= x;
            yReg     <= y;
            sumReg   <= '0;
            carryReg <= cIn;
            count    <= '0;
        end else if (state == RUN) begin
            xReg     <= xReg >> 1;
            yReg     <= yReg >> 1;
            sumReg   <= {sumBit, sumReg[N-1:1]};
            carryReg <= carryOut;
            // Counter stops at N, so it never wraps within an operation
            count    <= count + 1'b1;
        end
    end

    // Result registers: loaded only on the final step so partial sums never show
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z <= '0;
            c <= 1'b0;
            v <= 1'b0;
        end else if (state == RUN && lastStep) begin
            z <= {sumBit, sumReg[N-1:1]};
            c <= carryOut;
            // carryReg here is the carry into bit N-1
            v <= carryReg ^ carryOut;
        end
    end

    // Status outputs decoded from the state; cleared at once by the async reset
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (N=4): table vectors, corner-case
// sequences, and random operands checked against an arithmetic model.
module tb_serial_adder;

    localparam int N = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         cIn;
    logic [N-1:0] z;
    logic         c;
    logic         v;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;
    logic [N-1:0] lastZ = '0;

    serial_adder #(.N(N)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .x    (x),
        .y    (y),
        .cIn  (cIn),
        .z    (z),
        .c    (c),
        .v    (v),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         ci;
        logic [N-1:0] ez;
        logic         ec;
        logic         ev;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference: plain unsigned and signed arithmetic
    function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b, input logic ci,
                                  output logic [N-1:0] ez, output logic ec, output logic ev);
        int us;
        int sa;
        int sb;
        int ss;
        us = int'(a) + int'(b) + int'(ci);
        sa = a[N-1] ? int'(a) - (1 << N) : int'(a);
        sb = b[N-1] ? int'(b) - (1 << N) : int'(b);
        ss = sa + sb + int'(ci);
        ez = us[N-1:0];
        ec = us[N];
        ev = (ss > (1 << (N - 1)) - 1) || (ss < -(1 << (N - 1)));
    endfunction

    // One full operation from IDLE: latency, busy, result hold, done pulse width
    task automatic doOp(input string nm, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic ci, input logic [N-1:0] ez, input logic ec, input logic ev);
        int cycles;
        @(negedge clk);
        x = a; y = b; cIn = ci; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Operands scrambled after acceptance must not matter
        x = N'($urandom); y = N'($urandom); cIn = 1'($urandom);
        cycles = 1;
        chk({nm, " busy"}, 32'(busy), 32'd1);
        chk({nm, " z held in run"}, 32'(z), 32'(lastZ));
        while (!done && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        chk({nm, " latency"}, 32'(cycles), 32'(N + 1));
        chk({nm, " z"}, 32'(z), 32'(ez));
        chk({nm, " c"}, 32'(c), 32'(ec));
        chk({nm, " v"}, 32'(v), 32'(ev));
        chk({nm, " busy in done"}, 32'(busy), 32'd0);
        lastZ = ez;
        @(negedge clk);
        chk({nm, " done width"}, 32'(done), 32'd0);
    endtask

    initial begin
        int doneCnt;
        int doneAt[$];
        logic [N-1:0] ez;
        logic ec;
        logic ev;
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic rc;

        vecs[0] = '{"zero",     4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
        vecs[1] = '{"7p1",      4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1};
        vecs[2] = '{"8p8",      4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1};
        vecs[3] = '{"fp1",      4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0};
        vecs[4] = '{"fpfc",     4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0};
        vecs[5] = '{"5p6c",     4'b0101, 4'b0110, 1'b1, 4'b1100, 1'b0, 1'b1};

        // Reset: outputs clear without a clock edge, start ignored while held
        rst = 1'b1; start = 1'b1; x = 4'b0111; y = 4'b0001; cIn = 1'b0;
        #3;
        chk("reset z", 32'(z), 32'd0);
        chk("reset c", 32'(c), 32'd0);
        chk("reset v", 32'(v), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        chk("start ignored in reset", 32'(busy), 32'd0);
        rst = 1'b0; start = 1'b0;

        for (int i = 0; i < 6; i++) begin
            doOp(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].ci,
                 vecs[i].ez, vecs[i].ec, vecs[i].ev);
        end

        // Start pulsed mid-run with new operands: ignored
        @(negedge clk);
        x = 4'b0010; y = 4'b0001; cIn = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        x = 4'b1111; y = 4'b1111; cIn = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; x = 4'b1010; y = 4'b0110;
        doneCnt = 0;
        for (int i = 4; i <= 14; i++) begin
            @(negedge clk);
            if (done) begin
                doneCnt++;
                chk("ignore start done time", 32'(i), 32'(N + 1));
                chk("ignore start z", 32'(z), 32'b0011);
                chk("ignore start c", 32'(c), 32'd0);
                chk("ignore start v", 32'(v), 32'd0);
            end
        end
        chk("ignore start pulses", 32'(doneCnt), 32'd1);
        lastZ = 4'b0011;

        // Start held high: a result every N+2 cycles
        x = 4'b0001; y = 4'b0010; cIn = 1'b1; start = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done) begin
                doneAt.push_back(i);
                chk("b2b z", 32'(z), 32'b0100);
                chk("b2b c", 32'(c), 32'd0);
                chk("b2b v", 32'(v), 32'd0);
            end
        end
        start = 1'b0;
        chk("b2b pulse count", 32'(doneAt.size()), 32'd5);
        if (doneAt.size() > 0) chk("b2b first done", 32'(doneAt[0]), 32'(N + 1));
        for (int i = 1; i < doneAt.size(); i++) begin
            chk("b2b spacing", 32'(doneAt[i] - doneAt[i-1]), 32'(N + 2));
        end
        lastZ = 4'b0100;
        @(negedge clk);

        // Reset two cycles into RUN: immediate clear, no done afterwards
        @(negedge clk);
        x = 4'b0101; y = 4'b0011; cIn = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("pre-abort busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort z", 32'(z), 32'd0);
        chk("abort c", 32'(c), 32'd0);
        chk("abort v", 32'(v), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        doneCnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) doneCnt++;
        end
        chk("abort no activity", 32'(doneCnt), 32'd0);
        lastZ = '0;
        doOp("after abort", 4'b0001, 4'b0001, 1'b0, 4'b0010, 1'b0, 1'b0);

        // Random operands against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            rc = 1'($urandom);
            model(ra, rb, rc, ez, ec, ev);
            doOp("random", ra, rb, rc, ez, ec, ev);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter N, default 4, giving the operand and result width in bits (N >= 2).
REQ-002 SHALL have clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have start  input  1  request to begin an addition; sampled on the rising edge of clk.
REQ-005 SHALL have x  input  N  first operand (augend); two's complement for the v flag.
REQ-006 SHALL have y  input  N  second operand (addend).
REQ-007 SHALL have cIn  input  1  carry-in.
REQ-008 SHALL have z  output  N  sum x + y + cIn modulo 2^N, registered.
REQ-009 SHALL have c  output  1  carry-out of bit N-1, registered.
REQ-010 SHALL have v  output  1  signed overflow (carry into bit N-1 XOR carry out of bit N-1), registered.
REQ-011 SHALL have busy  output  1  high while an addition is in progress.
REQ-012 SHALL have done  output  1  one-cycle pulse marking z, c and v as updated with a new result.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 IDLE: when start=1 at a clock edge, SHALL latch x, y and cIn into internal shift and carry registers, clear the bit counter, and enter RUN; start=0 stays in IDLE.
REQ-015 RUN: each clock edge SHALL perform one full-adder step on the operand LSBs and the carry register, shift both operand registers right by one, shift the sum bit into the MSB of the result shift register, update the carry register, and increment the counter.
REQ-016 RUN SHALL last exactly N edges, processing bits 0..N-1 in order; on the edge that processes bit N-1 it SHALL load z, c and v and enter DONE.
REQ-017 Latency: if start is accepted at edge k, done SHALL be high during the cycle following edge k+N.
REQ-018 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-019 busy SHALL be 1 in RUN only, and 0 in IDLE and DONE.
REQ-020 start SHALL be ignored in RUN and DONE; the in-progress operands are unaffected.
REQ-021 Changes to x, y or cIn after the accepting edge SHALL NOT affect the result.
REQ-022 z, c and v SHALL hold their last result from DONE until the next DONE; they SHALL NOT show partial sums during RUN.
REQ-023 v SHALL be computed as the carry into bit N-1 XOR the carry out of bit N-1, captured during the final RUN step.
REQ-024 The counter SHALL be ceil(log2(N+1)) bits wide and SHALL NOT wrap during an operation.
REQ-025 Back-to-back operation: start held high SHALL be accepted again in the first IDLE cycle after DONE, giving one result every N+2 cycles.

Reset
REQ-026 rst=1 SHALL immediately force the FSM to IDLE and clear z, c, v, busy, done, the counter and all internal registers to 0, without waiting for a clock edge.
REQ-027 rst asserted during RUN or DONE SHALL abandon the operation; no done pulse SHALL follow.
REQ-028 While rst=1, start SHALL be ignored; the first possible acceptance is the first rising edge with rst=0.

Verification (N=4)
REQ-029 x=0000 y=0000 cIn=0, start for 1 cycle -> busy for 4 cycles, then done pulse; z=0000 c=0 v=0.
REQ-030 x=0111 y=0001 cIn=0 -> z=1000 c=0 v=1; and x=1000 y=1000 cIn=0 -> z=0000 c=1 v=1.
REQ-031 x=1111 y=0001 cIn=0 -> z=0000 c=1 v=0; and x=1111 y=1111 cIn=1 -> z=1111 c=1 v=0.
REQ-032 Start x=0010 y=0001; 2 cycles later pulse start with x=1111 y=1111 and change the operands -> only one done pulse, with z=0011 c=0 v=0.
REQ-033 Assert rst 2 cycles into RUN -> all outputs 0 immediately, no done pulse; a new start of 0001+0001 then gives z=0010 c=0 v=0 after 4 cycles.
REQ-034 Hold start high with x=0001 y=0010 cIn=1 -> done pulses every 6 cycles, each with z=0100 c=0 v=0.
